// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_ctrl_pkg: shared state encoding and counter stage width for the sequencer
package counter_seq_ctrl_pkg;
  localparam int STAGE_W = 4;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, ABORT} state_t;
endpackage

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: host controls/status plus counter-chain pins of the sequencer
//   host side : START, STOP, MODE, PRESET in; BUSY, DONE, TICK, WRAPS out
//   chain side: CNT_RCO in; CNT_D, CNT_CLR_n, CNT_LOAD_n, CNT_ENP, CNT_ENT out
//   master = controller, slave = host plus counter chain
interface counter_seq_ctrl_if
  import counter_seq_ctrl_pkg::*;
#(
  parameter int NSTAGE = 1,
  parameter int WRAPW  = 8
);
  localparam int W = STAGE_W * NSTAGE;
  logic             START;
  logic             STOP;
  logic             MODE;
  logic [W-1:0]     PRESET;
  logic             CNT_RCO;
  logic [W-1:0]     CNT_D;
  logic             CNT_CLR_n;
  logic             CNT_LOAD_n;
  logic             CNT_ENP;
  logic             CNT_ENT;
  logic             BUSY;
  logic             DONE;
  logic             TICK;
  logic [WRAPW-1:0] WRAPS;
  modport master (
    input  START, STOP, MODE, PRESET, CNT_RCO,
    output CNT_D, CNT_CLR_n, CNT_LOAD_n, CNT_ENP, CNT_ENT, BUSY, DONE, TICK, WRAPS
  );
  modport slave (
    output START, STOP, MODE, PRESET, CNT_RCO,
    input  CNT_D, CNT_CLR_n, CNT_LOAD_n, CNT_ENP, CNT_ENT, BUSY, DONE, TICK, WRAPS
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: start/pause/resume/abort, one-shot and auto-reload sequencer for a 74LS161 chain
//   CLK, CLR (async, active-high) plain ports; everything else through bus (master modport)
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int NSTAGE = 1,
  parameter int WRAPW  = 8
) (
  input logic                CLK,
  input logic                CLR,
  counter_seq_ctrl_if.master bus
);
  localparam int W = STAGE_W * NSTAGE;
  state_t           state, state_nx;
  logic [W-1:0]     preset_q;
  logic             mode_q;
  logic [WRAPW-1:0] wraps_q;
  logic             done_q, tick_q;
  logic             go, term;
  assign go   = state == IDLE && bus.START && !bus.STOP;
  assign term = state == RUN && bus.CNT_RCO;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? LOAD : IDLE;
      LOAD:    state_nx = RUN;
      RUN:     state_nx = (term && !mode_q) ? IDLE : bus.STOP ? PAUSE : RUN;
      PAUSE:   state_nx = bus.STOP ? ABORT : bus.START ? RUN : PAUSE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // CLR reaches the chain clear directly so the chain resets together with the controller
  always_comb begin
    bus.CNT_D      = preset_q;
    bus.CNT_CLR_n  = !CLR && state != ABORT;
    bus.CNT_LOAD_n = !(state == LOAD || (term && mode_q));
    bus.CNT_ENP    = state == RUN && !bus.CNT_RCO;
    bus.CNT_ENT    = state == RUN;
    bus.BUSY       = state == LOAD || state == RUN || state == PAUSE;
    bus.DONE       = done_q;
    bus.TICK       = tick_q;
    bus.WRAPS      = wraps_q;
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      preset_q <= '0;
      mode_q   <= 1'b0;
      wraps_q  <= '0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= term && !mode_q;
      tick_q <= term && mode_q;
      if (go) begin
        preset_q <= bus.PRESET;
        mode_q   <= bus.MODE;
        wraps_q  <= '0;
      end else if (term && mode_q && !(&wraps_q)) begin
        wraps_q <= wraps_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: scoreboard bench driving the sequencer into modelled 74LS161 chains
module counter_chain #(
  parameter int NSTAGE = 1
) (
  input  logic                CLK,
  input  logic [4*NSTAGE-1:0] D,
  input  logic                CLR_n,
  input  logic                LOAD_n,
  input  logic                ENP,
  input  logic                ENT,
  output logic [4*NSTAGE-1:0] Q,
  output logic                RCO
);
  logic [NSTAGE:0] t;
  assign t[0] = ENT;
  for (genvar i = 0; i < NSTAGE; i++) begin : g
    logic [3:0] q;
    always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) q <= 4'd0;
      else if (!LOAD_n) q <= D[4*i+:4];
      else if (ENP && t[i]) q <= q + 4'd1;
    end
    assign Q[4*i+:4] = q;
    assign t[i+1] = t[i] && (&q);
  end
  assign RCO = t[NSTAGE];
endmodule

module tb_counter_seq_ctrl;
  typedef struct {
    bit          tick;
    bit          busy;
    logic [7:0]  q;
    logic [7:0]  wraps;
    int          gap;
  } ev_t;
  logic clk = 1'b0;
  logic CLR = 1'b1;
  logic [3:0] q1;
  logic [7:0] q2;
  int tests = 0, fails = 0;
  int ev1 = 0, ev2 = 0;
  bit watch = 1'b0, lowq = 1'b0;
  ev_t exp1[$], exp2[$];
  counter_seq_ctrl_if #(.NSTAGE(1), .WRAPW(8)) b1();
  counter_seq_ctrl_if #(.NSTAGE(2), .WRAPW(8)) b2();
  counter_seq_ctrl #(.NSTAGE(1), .WRAPW(8)) dut1 (.CLK(clk), .CLR(CLR), .bus(b1));
  counter_seq_ctrl #(.NSTAGE(2), .WRAPW(8)) dut2 (.CLK(clk), .CLR(CLR), .bus(b2));
  counter_chain #(.NSTAGE(1)) ch1 (.CLK(clk), .D(b1.CNT_D), .CLR_n(b1.CNT_CLR_n), .LOAD_n(b1.CNT_LOAD_n),
    .ENP(b1.CNT_ENP), .ENT(b1.CNT_ENT), .Q(q1), .RCO(b1.CNT_RCO));
  counter_chain #(.NSTAGE(2)) ch2 (.CLK(clk), .D(b2.CNT_D), .CLR_n(b2.CNT_CLR_n), .LOAD_n(b2.CNT_LOAD_n),
    .ENP(b2.CNT_ENP), .ENT(b2.CNT_ENT), .Q(q2), .RCO(b2.CNT_RCO));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmp_ev(input string tag, input ev_t e, input logic tick, input logic busy,
                        input logic [7:0] q, input logic [7:0] wraps, input int gap);
    chk({tag, "_kind"}, tick, e.tick);
    chk({tag, "_busy"}, busy, e.busy);
    chk({tag, "_q"}, q, e.q);
    chk({tag, "_wraps"}, wraps, e.wraps);
    if (e.gap != 0) chk({tag, "_period"}, gap, e.gap);
  endtask
  initial begin : mon1
    int gap = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      gap++;
      if (watch && b1.CNT_ENT && q1 < 4'd2) lowq = 1'b1;
      if (b1.DONE || b1.TICK) begin
        chk("done_tick_excl1", b1.DONE && b1.TICK, 0);
        if (exp1.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event1: done=%0b tick=%0b with nothing expected", b1.DONE, b1.TICK);
        end else begin
          e = exp1.pop_front();
          cmp_ev("ev1", e, b1.TICK, b1.BUSY, {4'd0, q1}, b1.WRAPS, gap);
        end
        ev1++;
        gap = 0;
      end
    end
  end
  initial begin : mon2
    int gap = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      gap++;
      if (b2.DONE || b2.TICK) begin
        chk("done_tick_excl2", b2.DONE && b2.TICK, 0);
        if (exp2.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event2: done=%0b tick=%0b with nothing expected", b2.DONE, b2.TICK);
        end else begin
          e = exp2.pop_front();
          cmp_ev("ev2", e, b2.TICK, b2.BUSY, q2, b2.WRAPS, gap);
        end
        ev2++;
        gap = 0;
      end
    end
  end
  task automatic start1(input logic mode, input logic [3:0] preset);
    b1.START = 1'b1; b1.MODE = mode; b1.PRESET = preset;
    @(negedge clk);
    b1.START = 1'b0; b1.MODE = ~mode; b1.PRESET = 4'h9;
  endtask
  task automatic wait_q1(input logic [3:0] v, input int budget);
    int n = 0;
    while (q1 !== v && n < budget) begin @(negedge clk); n++; end
    if (q1 !== v) begin
      tests++; fails++;
      $display("FAIL wait_q1_timeout: got %0h required %0h", q1, v);
    end
  endtask
  task automatic wait_ev1(input int target, input int budget);
    int n = 0;
    while (ev1 < target && n < budget) begin @(negedge clk); n++; end
    if (ev1 < target) begin
      tests++; fails++;
      $display("FAIL wait_ev1_timeout: got %0d events required %0d", ev1, target);
    end
  endtask
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin : stim
    int base;
    {b1.START, b1.STOP, b1.MODE, b1.PRESET} = '0;
    {b2.START, b2.STOP, b2.MODE, b2.PRESET} = '0;
    #3 chk("rst_clr_n", b1.CNT_CLR_n, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", b1.BUSY, 0);
    chk("rst_done", b1.DONE, 0);
    chk("rst_tick", b1.TICK, 0);
    chk("rst_wraps", b1.WRAPS, 0);
    chk("rst_q", q1, 0);
    chk("rst_cnt_d", b1.CNT_D, 0);
    chk("rst_wraps2", b2.WRAPS, 0);
    CLR = 1'b0;
    @(negedge clk);
    chk("idle_clr_n", b1.CNT_CLR_n, 1);
    chk("idle_load_n", b1.CNT_LOAD_n, 1);
    chk("idle_enp", b1.CNT_ENP, 0);
    chk("idle_ent", b1.CNT_ENT, 0);
    b1.START = 1'b1; b1.STOP = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_stop_idle", b1.BUSY, 0);
    b1.START = 1'b0; b1.STOP = 1'b0;
    // one-shot from 2: fourteen RUN cycles, DONE with Q held at 15
    exp1.push_back('{tick: 0, busy: 0, q: 8'd15, wraps: 8'd0, gap: 0});
    base = ev1;
    start1(1'b0, 4'd2);
    chk("load_load_n", b1.CNT_LOAD_n, 0);
    chk("load_busy", b1.BUSY, 1);
    chk("load_cnt_d", b1.CNT_D, 2);
    wait_ev1(base + 1, 40);
    @(negedge clk);
    chk("oneshot_hold_q", q1, 15);
    chk("oneshot_idle_busy", b1.BUSY, 0);
    // auto-reload from 2: period 14, never passes through 0 or 1
    for (int i = 1; i <= 3; i++)
      exp1.push_back('{tick: 1, busy: 1, q: 8'd2, wraps: 8'(i), gap: (i == 1) ? 0 : 14});
    base = ev1;
    start1(1'b1, 4'd2);
    watch = 1'b1;
    wait_ev1(base + 3, 80);
    chk("reload_wraps3", b1.WRAPS, 3);
    watch = 1'b0;
    chk("reload_no_low_q", lowq, 0);
    // pause at 6, resume to 7, then abort
    wait_q1(4'd5, 20);
    b1.STOP = 1'b1;
    @(negedge clk);
    b1.STOP = 1'b0;
    chk("pause_q", q1, 6);
    chk("pause_enp", b1.CNT_ENP, 0);
    chk("pause_ent", b1.CNT_ENT, 0);
    chk("pause_busy", b1.BUSY, 1);
    repeat (3) @(negedge clk);
    chk("pause_hold_q", q1, 6);
    b1.START = 1'b1;
    @(negedge clk);
    b1.START = 1'b0;
    chk("resume_no_reload", q1, 6);
    @(negedge clk);
    chk("resume_step", q1, 7);
    b1.STOP = 1'b1;
    repeat (2) @(negedge clk);
    b1.STOP = 1'b0;
    chk("abort_clr_n", b1.CNT_CLR_n, 0);
    chk("abort_q", q1, 0);
    @(negedge clk);
    chk("abort_idle_busy", b1.BUSY, 0);
    chk("abort_idle_clr_n", b1.CNT_CLR_n, 1);
    // STOP in the terminal cycle: reload still happens, then PAUSE
    exp1.push_back('{tick: 1, busy: 1, q: 8'd2, wraps: 8'd1, gap: 0});
    start1(1'b1, 4'd2);
    wait_q1(4'd15, 30);
    b1.STOP = 1'b1;
    @(negedge clk);
    b1.STOP = 1'b0;
    chk("term_stop_q", q1, 2);
    chk("term_stop_tick", b1.TICK, 1);
    chk("term_stop_paused_enp", b1.CNT_ENP, 0);
    chk("term_stop_paused_ent", b1.CNT_ENT, 0);
    b1.STOP = 1'b1;
    @(negedge clk);
    b1.STOP = 1'b0;
    @(negedge clk);
    chk("term_stop_abort_busy", b1.BUSY, 0);
    chk("term_stop_abort_q", q1, 0);
    // short CLR pulse mid-RUN
    start1(1'b0, 4'd2);
    wait_q1(4'd9, 30);
    CLR = 1'b1;
    #1;
    chk("clr_pulse_clr_n", b1.CNT_CLR_n, 0);
    chk("clr_pulse_q", q1, 0);
    #1 CLR = 1'b0;
    @(negedge clk);
    chk("post_clr_busy", b1.BUSY, 0);
    chk("post_clr_done", b1.DONE, 0);
    chk("post_clr_tick", b1.TICK, 0);
    chk("post_clr_q", q1, 0);
    chk("post_clr_cnt_d", b1.CNT_D, 0);
    chk("post_clr_clr_n", b1.CNT_CLR_n, 1);
    exp1.push_back('{tick: 0, busy: 0, q: 8'd15, wraps: 8'd0, gap: 0});
    base = ev1;
    start1(1'b0, 4'd14);
    wait_ev1(base + 1, 20);
    // two stages from F0: period 16, WRAPS saturates at 255
    for (int i = 1; i <= 300; i++)
      exp2.push_back('{tick: 1, busy: 1, q: 8'hF0, wraps: (i > 255) ? 8'd255 : 8'(i), gap: (i == 1) ? 0 : 16});
    b2.START = 1'b1; b2.MODE = 1'b1; b2.PRESET = 8'hF0;
    @(negedge clk);
    b2.START = 1'b0; b2.MODE = 1'b0; b2.PRESET = 8'h00;
    begin
      int n = 0;
      while (ev2 < 300 && n < 5200) begin @(negedge clk); n++; end
    end
    chk("wide_reload_count", ev2, 300);
    chk("wide_wraps_sat", b2.WRAPS, 255);
    repeat (2) @(negedge clk);
    chk("exp1_drained", exp1.size(), 0);
    chk("exp2_drained", exp2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer for a chain of NSTAGE cascaded 4-bit synchronous presettable counters (74LS161 style: CLR_n, LOAD_n, ENP, ENT, RCO). It drives the chain's control pins to provide start, pause, resume, abort, one-shot and auto-reload timing. It sits between a host or register interface and the counter chain. Controller and chain share CLK.

Parameters:
NSTAGE, 1, number of cascaded 4-bit counter stages; chain width W = 4*NSTAGE
WRAPW, 8, width of the reload-event counter

Ports:
CLK  in  1  system clock; all state changes on the rising edge
CLR  in  1  asynchronous, active-high reset
START  in  1  level sampled each cycle; starts from IDLE, resumes from PAUSE
STOP  in  1  level sampled each cycle; pauses from RUN, aborts from PAUSE
MODE  in  1  0 = one-shot, 1 = auto-reload; sampled only on START from IDLE
PRESET  in  W  load value; latched on START from IDLE
CNT_RCO  in  1  ripple-carry output of the last stage
CNT_D  out  W  preset bus to the chain
CNT_CLR_n  out  1  chain clear, active-low
CNT_LOAD_n  out  1  chain synchronous load, active-low
CNT_ENP  out  1  chain count-enable P
CNT_ENT  out  1  chain count-enable T (gates RCO)
BUSY  out  1  high in states LOAD, RUN and PAUSE
DONE  out  1  one-cycle pulse on one-shot completion
TICK  out  1  one-cycle pulse on each auto-reload
WRAPS  out  WRAPW  saturating count of auto-reloads since the last start

Behaviour:
- Reset (CLR high): state = IDLE; preset_q = 0, mode_q = 0, WRAPS = 0; DONE = TICK = BUSY = 0. CNT_CLR_n is driven low combinationally while CLR is high, so the chain is cleared with the controller.
- States: IDLE, LOAD, RUN, PAUSE, ABORT. Outputs are decoded from state; the exceptions are CNT_LOAD_n and CNT_ENP in RUN, which also depend on CNT_RCO.
- CNT_D is always preset_q.
- IDLE: CLR_n = 1, LOAD_n = 1, ENP = 0, ENT = 0.
  - START & !STOP -> LOAD. Latch PRESET into preset_q and MODE into mode_q. Clear WRAPS.
- LOAD (exactly one cycle): LOAD_n = 0, ENP = 0, ENT = 0. The chain loads preset_q at the edge. -> RUN.
- RUN: ENT = 1.
  - Terminal cycle (CNT_RCO = 1), mode_q = 0: ENP = 0, so the chain holds at all-ones. -> IDLE, with DONE high in the next cycle. STOP is ignored in this cycle.
  - Terminal cycle (CNT_RCO = 1), mode_q = 1: LOAD_n = 0 (load has priority over count), so the chain reloads preset_q instead of wrapping. TICK is high in the next cycle. WRAPS += 1, saturating at all-ones. Next state is RUN, or PAUSE if STOP is also high; the reload still occurs.
  - Otherwise: ENP = 1, LOAD_n = 1. STOP -> PAUSE.
  - Reload period = 2^W - preset_q cycles. preset_q = all-ones gives a reload every cycle.
- PAUSE: ENP = 0, ENT = 0, so RCO is masked and Q holds.
  - STOP has priority -> ABORT.
  - Else START -> RUN, with no reload.
- ABORT (one cycle): CLR_n = 0, clearing the chain to 0. -> IDLE. No DONE.
- START while in LOAD or RUN is ignored. START and STOP together in IDLE: stay in IDLE.
- PRESET and MODE changes after start are ignored until the next start from IDLE.
- CLR asserted mid-operation: immediate return to IDLE with the chain cleared. No DONE or TICK is generated.
- DONE and TICK are registered, and are never both high in the same cycle.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, PAUSE, ABORT) and the 4-bit stage width constant.
- Controller RTL is a single module.
- Bench sub-module counter_chain: NSTAGE 74LS161-compatible counters cascaded via RCO -> ENT. It exposes the same D/CLR_n/LOAD_n/ENP/ENT/Q/RCO pins and is used as the DUT load.

Test Plan:
- NSTAGE = 1, MODE = 0, PRESET = 4'b0010, one-cycle START: one LOAD cycle; Q then steps 2 to 15 over 14 RUN cycles; Q holds at 15; DONE pulses once in the next cycle; BUSY falls with DONE; WRAPS = 0.
- MODE = 1, PRESET = 4'b0010: TICK every 14 cycles; Q sequence 2..15, 2..15 with no 0 or 1; after 3 reloads WRAPS = 3.
- MODE = 1, RUN at Q = 6, STOP for 1 cycle: PAUSE holds Q = 6 with ENP = ENT = 0. START for 1 cycle: RUN resumes at 7. STOP twice from PAUSE: ABORT clears Q to 0; IDLE; no DONE.
- MODE = 1, STOP high in the terminal cycle (Q = 15): Q reloads to 2, TICK = 1, state = PAUSE.
- CLR pulse of 2 ns mid-RUN at Q = 9: CNT_CLR_n is low during the pulse; Q = 0; IDLE; all outputs at reset values. A subsequent START works normally.
- NSTAGE = 2, MODE = 1, PRESET = 8'hF0, WRAPW = 8: period is 16 cycles; after 300 reloads WRAPS saturates at 255.
